// File: rtl/sensor_frame_assembler.sv
// Assembles 8 sensor bytes into four 16-bit channel words, conditions each
// (offset, arithmetic shift, signed saturation) and publishes them atomically.
module sensor_frame_assembler #(
    parameter logic [15:0] OFFSET_T = 16'h0000,
    parameter logic [15:0] OFFSET_L = 16'h0000,
    parameter logic [15:0] OFFSET_V = 16'h0000,
    parameter logic [15:0] OFFSET_P = 16'h0000,
    parameter int          SHIFT    = 0,
    parameter int          TIMEOUT  = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        frame_start_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [15:0] temp_o,
    output logic [15:0] light_o,
    output logic [15:0] voc_o,
    output logic [15:0] press_o,
    output logic        frame_valid_o,
    output logic        err_o,
    output logic [15:0] frame_count_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PROCESS, S_PUBLISH} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [1:0]             ch_q, ch_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0][7:0]        raw_q, raw_d;
    logic [3:0][15:0]       shd_q, shd_d;
    logic [3:0][15:0]       out_q, out_d;
    logic                   fv_q, fv_d;
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   accept;
    logic [15:0]            raw_word;
    logic [15:0]            offset;

    // 17-bit signed difference keeps the full range of raw - offset before saturation.
    function automatic logic [15:0] condition(input logic [15:0] raw, input logic [15:0] off);
        logic signed [16:0] d;
        logic signed [16:0] s;
        d = $signed({1'b0, raw}) - $signed({1'b0, off});
        s = d >>> SHIFT;
        if (!s[16] && s[15])      return 16'h7FFF;
        else if (s[16] && !s[15]) return 16'h8000;
        else                      return s[15:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ch_q    <= '0;
            tmo_q   <= '0;
            raw_q   <= '0;
            shd_q   <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            tmo_q   <= tmo_d;
            raw_q   <= raw_d;
            shd_q   <= shd_d;
            out_q   <= out_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        raw_word = {raw_q[{ch_q, 1'b0}], raw_q[{ch_q, 1'b1}]};
        case (ch_q)
            2'd0:    offset = OFFSET_T;
            2'd1:    offset = OFFSET_L;
            2'd2:    offset = OFFSET_V;
            default: offset = OFFSET_P;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        tmo_d   = tmo_q;
        raw_d   = raw_q;
        shd_d   = shd_q;
        out_d   = out_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        accept  = byte_valid_i && byte_ready_o;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d = S_COLLECT;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_COLLECT: begin
                if (frame_start_i) begin
                    // Resync: a coincident byte is the first byte of the new frame.
                    err_d = 1'b1;
                    tmo_d = '0;
                    if (accept) begin
                        raw_d[0] = byte_in_i;
                        idx_d    = 3'd1;
                    end else begin
                        idx_d = '0;
                    end
                end else if (accept) begin
                    raw_d[idx_q] = byte_in_i;
                    idx_d        = idx_q + 3'd1;
                    tmo_d        = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_PROCESS;
                        ch_d    = '0;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_PROCESS: begin
                shd_d[ch_q] = condition(raw_word, offset);
                ch_d        = ch_q + 2'd1;
                if (ch_q == 2'd3) state_d = S_PUBLISH;
            end
            default: begin
                out_d   = shd_q;
                fv_d    = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_ready_o  = (state_q == S_IDLE) || (state_q == S_COLLECT);
        temp_o        = out_q[0];
        light_o       = out_q[1];
        voc_o         = out_q[2];
        press_o       = out_q[3];
        frame_valid_o = fv_q;
        err_o         = err_q;
        frame_count_o = cnt_q;
    end

endmodule

// File: tb/tb_sensor_frame_assembler.sv
// Directed bench: three parameterisations share one byte stream; expected
// words are hand-computed from the offset/shift/saturation rules.
module tb_sensor_frame_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        ready [3];
    logic [15:0] temp [3];
    logic [15:0] light [3];
    logic [15:0] voc [3];
    logic [15:0] press [3];
    logic        fv [3];
    logic        err [3];
    logic [15:0] cnt [3];

    int errors = 0;
    int checks = 0;
    int n_err = 0;
    int n_fv = 0;

    always #5 clk = ~clk;

    sensor_frame_assembler #(.TIMEOUT(20)) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(frame_start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(ready[0]), .temp_o(temp[0]), .light_o(light[0]),
        .voc_o(voc[0]), .press_o(press[0]), .frame_valid_o(fv[0]), .err_o(err[0]),
        .frame_count_o(cnt[0]));

    sensor_frame_assembler #(.OFFSET_T(16'h1000), .SHIFT(1), .TIMEOUT(20)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(frame_start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(ready[1]), .temp_o(temp[1]), .light_o(light[1]),
        .voc_o(voc[1]), .press_o(press[1]), .frame_valid_o(fv[1]), .err_o(err[1]),
        .frame_count_o(cnt[1]));

    sensor_frame_assembler #(.OFFSET_L(16'h9000), .SHIFT(0), .TIMEOUT(20)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .frame_start_i(frame_start), .byte_in_i(byte_in),
        .byte_valid_i(byte_valid), .byte_ready_o(ready[2]), .temp_o(temp[2]), .light_o(light[2]),
        .voc_o(voc[2]), .press_o(press[2]), .frame_valid_o(fv[2]), .err_o(err[2]),
        .frame_count_o(cnt[2]));

    always @(negedge clk) begin
        if (err[0]) n_err++;
        if (fv[0])  n_fv++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic feed(input logic [63:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            byte_in    = fr[63-8*i -: 8];
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_fv(output int lat);
        lat = 0;
        while (!fv[0] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (temp[0] !== 16'h0 || press[0] !== 16'h0) begin errors++; $display("FAIL reset_out: temp=%h press=%h want 0", temp[0], press[0]); end
        checks++; if (cnt[0] !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", cnt[0]); end
        checks++; if (fv[0] !== 1'b0 || err[0] !== 1'b0) begin errors++; $display("FAIL reset_strobes: fv=%b err=%b want 0", fv[0], err[0]); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready[0]); end
    endtask

    task automatic test_defaults();
        int lat;
        int f0;
        f0 = n_fv;
        start();
        feed(64'h1234_0ABC_00FF_8000, 8);
        wait_fv(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL def_latency: got %0d want 5", lat); end
        checks++; if (temp[0] !== 16'h1234) begin errors++; $display("FAIL def_temp: got %h want 1234", temp[0]); end
        checks++; if (light[0] !== 16'h0ABC) begin errors++; $display("FAIL def_light: got %h want 0abc", light[0]); end
        checks++; if (voc[0] !== 16'h00FF) begin errors++; $display("FAIL def_voc: got %h want 00ff", voc[0]); end
        checks++; if (press[0] !== 16'h7FFF) begin errors++; $display("FAIL def_press_sat: got %h want 7fff", press[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL def_cnt: got %0d want 1", cnt[0]); end
        checks++; if (temp[1] !== 16'h011A || press[1] !== 16'h4000) begin errors++; $display("FAIL def_u1: temp=%h press=%h want 011a 4000", temp[1], press[1]); end
        checks++; if (light[2] !== 16'h8000) begin errors++; $display("FAIL def_u2_negsat: got %h want 8000", light[2]); end
        tick();
        checks++; if (fv[0] !== 1'b0 || n_fv - f0 !== 1) begin errors++; $display("FAIL def_fv_pulse: fv=%b pulses=%0d want 0/1", fv[0], n_fv - f0); end
    endtask

    task automatic test_offset_shift();
        int lat;
        start();
        feed(64'h3000_0000_1234_FFFF, 8);
        wait_fv(lat);
        checks++; if (temp[1] !== 16'h1000) begin errors++; $display("FAIL off_u1_temp: got %h want 1000", temp[1]); end
        checks++; if (voc[1] !== 16'h091A || press[1] !== 16'h7FFF) begin errors++; $display("FAIL off_u1_vp: voc=%h press=%h want 091a 7fff", voc[1], press[1]); end
        checks++; if (light[2] !== 16'h8000) begin errors++; $display("FAIL off_u2_light: got %h want 8000", light[2]); end
        checks++; if (temp[0] !== 16'h3000 || press[0] !== 16'h7FFF) begin errors++; $display("FAIL off_u0: temp=%h press=%h want 3000 7fff", temp[0], press[0]); end
        tick();
        start();
        feed(64'h0800_1000_0000_0000, 8);
        wait_fv(lat);
        checks++; if (temp[1] !== 16'hFC00) begin errors++; $display("FAIL off_u1_neg: got %h want fc00", temp[1]); end
        checks++; if (light[1] !== 16'h0800) begin errors++; $display("FAIL off_u1_light: got %h want 0800", light[1]); end
        checks++; if (light[2] !== 16'h8000) begin errors++; $display("FAIL off_u2_edge: got %h want 8000", light[2]); end
        checks++; if (cnt[0] !== 16'd3) begin errors++; $display("FAIL off_cnt: got %0d want 3", cnt[0]); end
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        int e0;
        int f0;
        e0 = n_err;
        f0 = n_fv;
        start();
        feed(64'hAABB_CC00_0000_0000, 3);
        lat = 0;
        while (!err[0] && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 20) begin errors++; $display("FAIL tmo_latency: got %0d want 20", lat); end
        tick();
        checks++; if (err[0] !== 1'b0 || n_err - e0 !== 1) begin errors++; $display("FAIL tmo_pulse: err=%b pulses=%0d want 0/1", err[0], n_err - e0); end
        checks++; if (temp[0] !== 16'h0800 || cnt[0] !== 16'd3) begin errors++; $display("FAIL tmo_hold: temp=%h cnt=%0d want 0800 3", temp[0], cnt[0]); end
        // Back in IDLE: bytes without frame_start must vanish.
        feed(64'h0102_0304_0506_0708, 8);
        repeat (10) tick();
        checks++; if (n_fv - f0 !== 0 || cnt[0] !== 16'd3) begin errors++; $display("FAIL tmo_idle: pulses=%0d cnt=%0d want 0 3", n_fv - f0, cnt[0]); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL tmo_idle_err: got %0d want 1", n_err - e0); end
    endtask

    task automatic test_resync();
        int lat;
        int e0;
        e0 = n_err;
        start();
        feed(64'hDEAD_BEEF_AA00_0000, 5);
        start();
        feed(64'h1111_2222_3333_4444, 8);
        wait_fv(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rsy_latency: got %0d want 5", lat); end
        checks++; if (temp[0] !== 16'h1111 || light[0] !== 16'h2222) begin errors++; $display("FAIL rsy_tl: temp=%h light=%h want 1111 2222", temp[0], light[0]); end
        checks++; if (voc[0] !== 16'h3333 || press[0] !== 16'h4444) begin errors++; $display("FAIL rsy_vp: voc=%h press=%h want 3333 4444", voc[0], press[0]); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL rsy_err: got %0d want 1", n_err - e0); end
        checks++; if (cnt[0] !== 16'd4) begin errors++; $display("FAIL rsy_cnt: got %0d want 4", cnt[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lo;
        int lat;
        frame_start = 1'b1;
        byte_valid  = 1'b1;
        byte_in     = 8'hEE;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_in = 8'(i + 1);
            tick();
        end
        byte_in = 8'h55;
        lo = 0;
        while (!ready[0] && lo < 20) begin
            tick();
            lo++;
        end
        checks++; if (lo !== 5) begin errors++; $display("FAIL b2b_ready_low: got %0d want 5", lo); end
        checks++; if (fv[0] !== 1'b1) begin errors++; $display("FAIL b2b_fv: got %b want 1", fv[0]); end
        checks++; if (temp[0] !== 16'h0102 || press[0] !== 16'h0708) begin errors++; $display("FAIL b2b_a: temp=%h press=%h want 0102 0708", temp[0], press[0]); end
        frame_start = 1'b1;
        byte_in     = 8'hEE;
        tick();
        frame_start = 1'b0;
        feed(64'h1A2B_3C4D_5E6F_7071, 8);
        wait_fv(lat);
        checks++; if (temp[0] !== 16'h1A2B || light[0] !== 16'h3C4D) begin errors++; $display("FAIL b2b_b_tl: temp=%h light=%h want 1a2b 3c4d", temp[0], light[0]); end
        checks++; if (voc[0] !== 16'h5E6F || press[0] !== 16'h7071) begin errors++; $display("FAIL b2b_b_vp: voc=%h press=%h want 5e6f 7071", voc[0], press[0]); end
        checks++; if (cnt[0] !== 16'd6) begin errors++; $display("FAIL b2b_cnt: got %0d want 6", cnt[0]); end
        tick();
    endtask

    task automatic test_midframe_reset();
        int lat;
        int e0;
        e0 = n_err;
        start();
        feed(64'h0102_0304_0506_0000, 6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (temp[0] !== 16'h0 || light[0] !== 16'h0 || voc[0] !== 16'h0 || press[0] !== 16'h0) begin errors++; $display("FAIL mrst_out: %h %h %h %h want 0", temp[0], light[0], voc[0], press[0]); end
        checks++; if (cnt[0] !== 16'd0 || ready[0] !== 1'b1) begin errors++; $display("FAIL mrst_cnt_rdy: cnt=%0d rdy=%b want 0 1", cnt[0], ready[0]); end
        tick();
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL mrst_err: got %0d want 0", n_err - e0); end
        start();
        feed(64'h0001_0002_0003_0004, 8);
        wait_fv(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL mrst_latency: got %0d want 5", lat); end
        checks++; if (temp[0] !== 16'h0001 || press[0] !== 16'h0004) begin errors++; $display("FAIL mrst_frame: temp=%h press=%h want 0001 0004", temp[0], press[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL mrst_cnt: got %0d want 1", cnt[0]); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_offset_shift();
        test_timeout();
        test_resync();
        test_back_to_back();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
